// File: rtl/aix_line_pkg.sv
// Shared constants, FSM state encoding and data typedefs for the line datapath
// (input loader / output storer).
package aix_line_pkg;

  localparam int WO             = 8;
  localparam int OFM_DATA_NUM   = 4;
  localparam int LINE_DATA_NUM  = 16;
  localparam int MAX_OFM_DEPTH  = 16;
  localparam int MAX_LINE_DEPTH = 8;

  localparam int LINE_W         = WO * LINE_DATA_NUM;
  localparam int WORD_W         = WO * OFM_DATA_NUM;
  localparam int WORDS_PER_LINE = LINE_DATA_NUM / OFM_DATA_NUM;
  localparam int SEL_W          = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAT,
    S_WR,
    S_DONE
  } state_e;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  sel_t;

endpackage

// File: rtl/line_word_select.sv
// Picks one 32-bit word of four channels out of a 128-bit line-BRAM word.
// With OUTPUT_RELU_EN defined, negative (bit 7 set) channel bytes are forced to zero.
module line_word_select
  import aix_line_pkg::*;
(
  input  line_t line_i,
  input  sel_t  sel_i,
  output word_t word_o
);

  // NOTE: every variable assigned in always_comb gets a full default first, so
  // no path can leave it holding a previous value (which would infer a latch).
  always_comb begin
    word_o = line_i[sel_i*WORD_W +: WORD_W];
`ifdef OUTPUT_RELU_EN
    for (int b = 0; b < OFM_DATA_NUM; b++) begin
      if (word_o[b*WO + WO - 1]) word_o[b*WO +: WO] = '0;
    end
`else
`endif
  end

endmodule

// File: rtl/output_line_storer.sv
// Write-back engine: reads one output line from the line BRAM and unpacks each pixel
// into 4-channel words at the feature-map slot for line_idx. Optional OUTPUT_RELU_EN.
module output_line_storer
  import aix_line_pkg::state_e, aix_line_pkg::S_IDLE, aix_line_pkg::S_RD,
         aix_line_pkg::S_LAT, aix_line_pkg::S_WR, aix_line_pkg::S_DONE;
#(
  parameter int OFM_DATA_NUM   = aix_line_pkg::OFM_DATA_NUM,
  parameter int WO             = aix_line_pkg::WO,
  parameter int LINE_DATA_NUM  = aix_line_pkg::LINE_DATA_NUM,
  parameter int MAX_OFM_DEPTH  = aix_line_pkg::MAX_OFM_DEPTH,
  parameter int MAX_LINE_DEPTH = aix_line_pkg::MAX_LINE_DEPTH
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [7:0]                    ofm_w,
  input  logic [7:0]                    och,
  input  logic [7:0]                    line_idx,
  input  logic                          ap_start,
  output logic [MAX_LINE_DEPTH-1:0]     r_addr,
  input  logic [WO*LINE_DATA_NUM-1:0]   r_data,
  output logic [MAX_OFM_DEPTH-1:0]      w_addr,
  output logic [WO*OFM_DATA_NUM-1:0]    w_data,
  output logic                          w_en,
  output logic                          ap_done
);

  localparam int KW = 6;  // och >> 2 for an 8-bit och

  state_e                          state_q;
  logic [7:0]                      ofm_w_q, x_q;
  logic [KW-1:0]                   k_q, j_q;
  logic [WO*LINE_DATA_NUM-1:0]     hold_q;
  logic [MAX_OFM_DEPTH-1:0]        addr_q;
  logic [MAX_LINE_DEPTH-1:0]       r_addr_q;
  logic [MAX_OFM_DEPTH-1:0]        w_addr_q;
  logic [WO*OFM_DATA_NUM-1:0]      w_data_q;
  logic                            w_en_q, ap_done_q;

  logic [KW-1:0]                   k_in;
  logic [MAX_OFM_DEPTH-1:0]        base_in;
  logic [WO*LINE_DATA_NUM-1:0]     sel_line;
  aix_line_pkg::sel_t              sel_idx;
  logic [WO*OFM_DATA_NUM-1:0]      sel_word;

  assign k_in    = KW'(och >> 2);
  assign base_in = MAX_OFM_DEPTH'(MAX_OFM_DEPTH'(line_idx) * MAX_OFM_DEPTH'(ofm_w)
                                  * MAX_OFM_DEPTH'(k_in));

  // Word 0 of a pixel comes straight off the BRAM output in LAT; later words from hold_q.
  assign sel_line = (state_q == S_LAT) ? r_data : hold_q;
  assign sel_idx  = (state_q == S_LAT) ? '0 : aix_line_pkg::sel_t'(j_q + KW'(1));

  line_word_select u_sel (
    .line_i (sel_line),
    .sel_i  (sel_idx),
    .word_o (sel_word)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      ofm_w_q   <= '0;
      x_q       <= '0;
      k_q       <= '0;
      j_q       <= '0;
      // NOTE: the wide hold register is reset too; it is a plain flop bank, not a
      // RAM, and a known value keeps w_data free of X after an abandoned transfer.
      hold_q    <= '0;
      addr_q    <= '0;
      r_addr_q  <= '0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      w_en_q    <= 1'b0;
      ap_done_q <= 1'b0;
    end else begin
      w_en_q    <= 1'b0;
      ap_done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (ap_start) begin
          ofm_w_q  <= ofm_w;
          k_q      <= k_in;
          x_q      <= '0;
          r_addr_q <= '0;
          addr_q   <= base_in;
          if (ofm_w == 8'd0 || k_in == '0) begin
            state_q   <= S_DONE;
            ap_done_q <= 1'b1;
          end else begin
            state_q <= S_RD;
          end
        end
        S_RD: state_q <= S_LAT;
        S_LAT: begin
          hold_q   <= r_data;
          j_q      <= '0;
          w_en_q   <= 1'b1;
          w_data_q <= sel_word;
          w_addr_q <= addr_q;
          addr_q   <= addr_q + 1'b1;
          state_q  <= S_WR;
        end
        S_WR: begin
          if (j_q != k_q - KW'(1)) begin
            j_q      <= j_q + KW'(1);
            w_en_q   <= 1'b1;
            w_data_q <= sel_word;
            w_addr_q <= addr_q;
            addr_q   <= addr_q + 1'b1;
          end else if (x_q == ofm_w_q - 8'd1) begin
            state_q   <= S_DONE;
            ap_done_q <= 1'b1;
          end else begin
            x_q      <= x_q + 8'd1;
            r_addr_q <= MAX_LINE_DEPTH'(x_q + 8'd1);
            state_q  <= S_RD;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign r_addr  = r_addr_q;
  assign w_addr  = w_addr_q;
  assign w_data  = w_data_q;
  assign w_en    = w_en_q;
  assign ap_done = ap_done_q;

endmodule

// File: tb/tb_output_line_storer.sv
// Directed self-checking bench for output_line_storer: line-BRAM and feature-map
// memory models, address/timing/data checks, mid-transfer disturbance and reset.
module tb_output_line_storer;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [7:0]   ofm_w = '0, och = '0, line_idx = '0;
  logic         ap_start = 1'b0;
  logic [7:0]   r_addr;
  logic [127:0] r_data;
  logic [15:0]  w_addr;
  logic [31:0]  w_data;
  logic         w_en, ap_done;

  output_line_storer dut (
    .clk      (clk),
    .rstn     (rstn),
    .ofm_w    (ofm_w),
    .och      (och),
    .line_idx (line_idx),
    .ap_start (ap_start),
    .r_addr   (r_addr),
    .r_data   (r_data),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_en     (w_en),
    .ap_done  (ap_done)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

  logic [127:0] line_mem [256];
  logic [31:0]  fm [65536];

  // Registered-output line BRAM.
  always @(posedge clk) r_data <= line_mem[r_addr];

  int n_checks = 0;
  int n_pass   = 0;

  int nwr, first_wen, done_at, addr_bad, bad;
  logic [15:0] first_addr, last_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_word(input logic [127:0] line, input int j);
    logic [31:0] w;
    w = line[32*j +: 32];
`ifdef OUTPUT_RELU_EN
    for (int b = 0; b < 4; b++) if (w[8*b+7]) w[8*b +: 8] = 8'h00;
`endif
    return w;
  endfunction

  task automatic fill_fm();
    for (int a = 0; a < 65536; a++) fm[a] = SENTINEL;
  endtask

  // Leaves the bench #1 after edge T, i.e. in cycle T+1.
  task automatic start_xfer(input logic [7:0] w, input logic [7:0] c, input logic [7:0] li);
    @(posedge clk); #1;
    ofm_w = w; och = c; line_idx = li; ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
  endtask

  // Samples cycle T+i for i = 1..budget, models the feature-map write, stops on ap_done.
  task automatic watch(input int budget, input bit disturb);
    nwr = 0; first_wen = -1; done_at = -1; addr_bad = 0;
    for (int i = 1; i <= budget; i++) begin
      if (disturb && i == 20) begin
        ap_start = 1'b1; ofm_w = 8'd5; line_idx = 8'd7; och = 8'd16;
      end
      if (disturb && i == 21) ap_start = 1'b0;
      if (w_en) begin
        if (nwr == 0) begin
          first_wen  = i;
          first_addr = w_addr;
        end else if (w_addr !== last_addr + 16'd1) begin
          addr_bad++;
        end
        last_addr = w_addr;
        fm[w_addr] = w_data;
        nwr++;
      end
      if (ap_done) begin
        done_at = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int x = 0; x < 256; x++) line_mem[x] = {$urandom, $urandom, $urandom, $urandom};
    fill_fm();

    repeat (3) @(posedge clk);
    #1;
    check("rst_r_addr", r_addr, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_w_data", w_data, 0);
    check("rst_w_en", w_en, 0);
    check("rst_ap_done", ap_done, 0);
    rstn = 1'b1;

    // Full line, line 0, 16 channels.
    start_xfer(8'd128, 8'd16, 8'd0);
    watch(2000, 1'b0);
    check("t1_nwr", nwr, 512);
    check("t1_first_wen", first_wen, 3);
    check("t1_first_addr", first_addr, 0);
    check("t1_last_addr", last_addr, 511);
    check("t1_addr_gap", addr_bad, 0);
    check("t1_done_at", done_at, 769);
    bad = 0;
    for (int x = 0; x < 128; x++)
      for (int j = 0; j < 4; j++)
        if (fm[x*4+j] !== exp_word(line_mem[x], j)) bad++;
    check("t1_data", bad, 0);
    @(posedge clk); #1;
    check("t1_done_pulse", ap_done, 0);

    // Same geometry at line 99.
    fill_fm();
    start_xfer(8'd128, 8'd16, 8'd99);
    watch(2000, 1'b0);
    check("t2_nwr", nwr, 512);
    check("t2_first_addr", first_addr, 50688);
    check("t2_last_addr", last_addr, 51199);
    check("t2_addr_gap", addr_bad, 0);
    bad = 0;
    for (int x = 0; x < 128; x++)
      for (int j = 0; j < 4; j++)
        if (fm[50688+x*4+j] !== exp_word(line_mem[x], j)) bad++;
    check("t2_data", bad, 0);
    bad = 0;
    for (int a = 0; a < 65536; a++)
      if ((a < 50688 || a > 51199) && fm[a] !== SENTINEL) bad++;
    check("t2_outside", bad, 0);

    // Small line, one word per pixel: 3 cycles per pixel.
    start_xfer(8'd4, 8'd4, 8'd2);
    watch(100, 1'b0);
    check("t3_nwr", nwr, 4);
    check("t3_first_wen", first_wen, 3);
    check("t3_first_addr", first_addr, 8);
    check("t3_last_addr", last_addr, 11);
    check("t3_done_at", done_at, 13);

    // Start pulse and input changes mid-transfer are ignored.
    fill_fm();
    start_xfer(8'd16, 8'd8, 8'd3);
    watch(200, 1'b1);
    check("t4_nwr", nwr, 32);
    check("t4_first_addr", first_addr, 96);
    check("t4_last_addr", last_addr, 127);
    check("t4_addr_gap", addr_bad, 0);
    check("t4_done_at", done_at, 65);
    bad = 0;
    for (int x = 0; x < 16; x++)
      for (int j = 0; j < 2; j++)
        if (fm[96+x*2+j] !== exp_word(line_mem[x], j)) bad++;
    check("t4_data", bad, 0);

    // Start held high across the DONE edge: ignored there, accepted one edge later.
    ap_start = 1'b1; ofm_w = 8'd4; och = 8'd4; line_idx = 8'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    watch(100, 1'b0);
    check("t5_first_wen", first_wen, 3);
    check("t5_first_addr", first_addr, 0);
    check("t5_done_at", done_at, 13);

    // Degenerate starts: no writes, done in T+1.
    start_xfer(8'd0, 8'd16, 8'd5);
    watch(10, 1'b0);
    check("t6_w0_done_at", done_at, 1);
    check("t6_w0_nwr", nwr, 0);
    start_xfer(8'd10, 8'd0, 8'd1);
    watch(10, 1'b0);
    check("t6_k0_done_at", done_at, 1);
    check("t6_k0_nwr", nwr, 0);

    // Reset during write 100.
    start_xfer(8'd128, 8'd16, 8'd0);
    nwr = 0;
    for (int i = 1; i <= 2000; i++) begin
      if (w_en) nwr++;
      if (nwr == 100) break;
      @(posedge clk); #1;
    end
    check("t7_reached_w100", nwr, 100);
    rstn = 1'b0;
    #1;
    check("t7_rst_w_en", w_en, 0);
    check("t7_rst_w_addr", w_addr, 0);
    check("t7_rst_w_data", w_data, 0);
    check("t7_rst_r_addr", r_addr, 0);
    check("t7_rst_ap_done", ap_done, 0);
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 3) rstn = 1'b1;
      @(posedge clk); #1;
      if (w_en || ap_done) bad++;
    end
    check("t7_quiet_after_rst", bad, 0);
    start_xfer(8'd4, 8'd4, 8'd2);
    watch(100, 1'b0);
    check("t7_restart_nwr", nwr, 4);
    check("t7_restart_first_addr", first_addr, 8);
    check("t7_restart_done_at", done_at, 13);

    // Clamp vector: channels 0..3 = 0x80, 0x7F, 0xFF, 0x01.
    line_mem[0] = {96'h0, 32'h01FF_7F80};
    fill_fm();
    start_xfer(8'd1, 8'd4, 8'd0);
    watch(20, 1'b0);
    check("t8_nwr", nwr, 1);
    check("t8_done_at", done_at, 4);
`ifdef OUTPUT_RELU_EN
    check("t8_word", fm[0], 32'h0100_7F00);
`else
    check("t8_word", fm[0], 32'h01FF_7F80);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
